// File: rtl/jk_bank_arbiter_pkg.sv
// Shared definitions for the JK bank arbiter: op codes, FSM states and the
// round-robin winner search.
package jk_pkg;

   localparam int MAX_REQ = 8;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_RST  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_TGL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_APPLY = 2'd2
   } st_t;

   // First requester at or after ptr, wrapping at nreq; 0 if none is asking.
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int                 nreq);
      logic [2:0] pick;
      logic       found;
      int         c;
      pick  = '0;
      found = 1'b0;
      for (int n = 0; n < MAX_REQ; n++) begin
         c = (int'(ptr) + n) % nreq;
         if (n < nreq && !found && req[c]) begin
            pick  = 3'(c);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bundle of the JK bank arbiter plus the FSM state for observation.
// Handshake: a requester raises req[i] with op/idx stable and holds it until
// ack[i] pulses for one cycle; it drops req the cycle after ack or is re-arbitrated.
interface jk_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int NBITS = 8,
   parameter int IDXW  = $clog2(NBITS)
);
   import jk_pkg::*;

   logic [NREQ-1:0]      req;
   logic [2*NREQ-1:0]    op;
   logic [IDXW*NREQ-1:0] idx;
   logic                 clear_all;
   logic [NREQ-1:0]      ack;
   logic                 busy;
   logic [NBITS-1:0]     q;
   logic [NBITS-1:0]     q_n;
   st_t                  fsm_state;

   modport master (
      output req, op, idx, clear_all,
      input  ack, busy, q, q_n, fsm_state
   );

   modport slave (
      input  req, op, idx, clear_all,
      output ack, busy, q, q_n, fsm_state
   );

endinterface

// File: rtl/jk_bank_arbiter_cell.sv
// One JK flip-flop of the bank with synchronous reset and synchronous clear.
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic j,
   input  logic k,
   output logic q,
   output logic q_n
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

   assign q_n = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK cells: IDLE latches a winner, GRANT
// drives J/K on the chosen cell, APPLY pulses ack and advances the pointer.
module jk_bank_arbiter
   import jk_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NBITS = 8
) (
   input  logic              input_clock1_c_1,
   input  logic              input_reset_2,
   jk_bank_arbiter_if.slave  bus
);

   localparam int IDXW = $clog2(NBITS);
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   st_t               state_q, state_d;
   logic [PW-1:0]     win_q, win_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [1:0]        op_q, op_d;
   logic [IDXW-1:0]   idx_q, idx_d;

   logic [MAX_REQ-1:0] req_pad;
   logic [2:0]         pick;
   logic [NREQ-1:0]    ack;
   logic               busy;
   logic [NBITS-1:0]   j, k;
   logic [NBITS-1:0]   q, q_n;

   always_comb begin
      req_pad            = '0;
      req_pad[NREQ-1:0]  = bus.req;
   end

   assign pick = rr_pick(req_pad, 3'(ptr_q), NREQ);

   always_ff @(posedge input_clock1_c_1) begin
      if (input_reset_2) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         ptr_q   <= '0;
         op_q    <= OP_HOLD;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      op_d    = op_q;
      idx_d   = idx_q;
      ack     = '0;
      busy    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A clear pulse suppresses a new grant in the same cycle.
            if (|bus.req && !bus.clear_all) begin
               win_d   = PW'(pick);
               op_d    = bus.op[2*int'(pick) +: 2];
               idx_d   = bus.idx[IDXW*int'(pick) +: IDXW];
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            busy    = 1'b1;
            state_d = bus.clear_all ? ST_IDLE : ST_APPLY;
         end
         ST_APPLY: begin
            busy       = 1'b1;
            ack[win_q] = 1'b1;
            if (int'(win_q) == NREQ - 1) begin
               ptr_d = '0;
            end else begin
               ptr_d = win_q + 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Indices that match no cell leave every J/K low, so out-of-range ops are no-ops.
   always_comb begin
      j = '0;
      k = '0;
      if (state_q == ST_GRANT && !bus.clear_all) begin
         for (int i = 0; i < NBITS; i++) begin
            if (idx_q == IDXW'(i)) begin
               j[i] = op_q[1];
               k[i] = op_q[0];
            end
         end
      end
   end

   for (genvar g = 0; g < NBITS; g++) begin : g_cell
      jk_cell u_cell (
         .clk (input_clock1_c_1),
         .rst (input_reset_2),
         .clr (bus.clear_all),
         .j   (j[g]),
         .k   (k[g]),
         .q   (q[g]),
         .q_n (q_n[g])
      );
   end

   assign bus.ack       = ack;
   assign bus.busy      = busy;
   assign bus.q         = q;
   assign bus.q_n       = q_n;
   assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level model of the bank.
module tb_jk_bank_arbiter;
   import jk_pkg::*;

   localparam int NREQ = 4;
   localparam int NB   = 8;
   localparam int NBB  = 6;
   localparam int IW   = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jk_bank_arbiter_if #(.NREQ(NREQ), .NBITS(NB))  ifa ();
   jk_bank_arbiter_if #(.NREQ(NREQ), .NBITS(NBB)) ifb ();

   jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NB)) dut_a (
      .input_clock1_c_1 (clk),
      .input_reset_2    (rst),
      .bus              (ifa)
   );

   jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBB)) dut_b (
      .input_clock1_c_1 (clk),
      .input_reset_2    (rst),
      .bus              (ifb)
   );

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   logic [31:0] exp_q[$];

   // ---------------- reference model (bank A) ----------------
   // A transaction is "latched" for one cycle, then "applying" for one cycle.
   logic [NB-1:0]   m_q    = '0;
   logic [NREQ-1:0] m_ackv = '0;
   int m_age = 0;
   int m_win = 0, m_op = 0, m_idx = 0, m_ptr = 0;

   task automatic model_step();
      bit found;
      int c;
      if (rst) begin
         m_q = '0; m_age = 0; m_ptr = 0; m_win = 0;
      end else begin
         if (ifa.clear_all) m_q = '0;
         if (m_age == 2) begin
            m_ptr = (m_win + 1) % NREQ;
            m_age = 0;
         end else if (m_age == 1) begin
            if (ifa.clear_all) begin
               m_age = 0;
            end else begin
               if (m_idx < NB) begin
                  if (m_op == 1) m_q[m_idx] = 1'b0;
                  else if (m_op == 2) m_q[m_idx] = 1'b1;
                  else if (m_op == 3) m_q[m_idx] = ~m_q[m_idx];
               end
               m_age = 2;
            end
         end else if (!ifa.clear_all && ifa.req != '0) begin
            found = 0;
            for (int n = 0; n < NREQ; n++) begin
               c = (m_ptr + n) % NREQ;
               if (!found && ifa.req[c]) begin
                  found = 1;
                  m_win = c;
               end
            end
            m_op  = int'(ifa.op[2*m_win +: 2]);
            m_idx = int'(ifa.idx[IW*m_win +: IW]);
            m_age = 1;
         end
      end
      m_ackv = '0;
      if (m_age == 2) m_ackv[m_win] = 1'b1;
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [NB-1:0] qn_exp;
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      qn_exp = ~m_q;
      chk("q", 32'(ifa.q), 32'(m_q));
      chk("q_n", 32'(ifa.q_n), 32'(qn_exp));
      chk("ack", 32'(ifa.ack), 32'(m_ackv));
      chk("busy", 32'(ifa.busy), 32'(m_age != 0));
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int r, input logic [1:0] o, input logic [2:0] ix);
      ifa.op[2*r +: 2]   = o;
      ifa.idx[IW*r +: IW] = ix;
      ifa.req[r]         = 1'b1;
   endtask

   task automatic run_op(input int r, input logic [1:0] o, input logic [2:0] ix);
      logic [31:0] one;
      bit got;
      one = 32'd1 << r;
      set_req(r, o, ix);
      got = 0;
      for (int n = 0; n < 8 && !got; n++) begin
         tick();
         if (ifa.ack != '0) got = 1;
      end
      chk("run_ack", 32'(ifa.ack), one);
      ifa.req[r] = 1'b0;
      tick();
   endtask

   task automatic run_op_b(input logic [1:0] o, input logic [2:0] ix, input logic [NBB-1:0] q_exp);
      logic [NBB-1:0] qn_exp;
      bit got;
      qn_exp     = ~q_exp;
      ifb.op[1:0]  = o;
      ifb.idx[2:0] = ix;
      ifb.req[0]   = 1'b1;
      got = 0;
      for (int n = 0; n < 8 && !got; n++) begin
         tick();
         if (ifb.ack != '0) got = 1;
      end
      chk("b_ack", 32'(ifb.ack), 32'd1);
      chk("b_q", 32'(ifb.q), 32'(q_exp));
      chk("b_q_n", 32'(ifb.q_n), 32'(qn_exp));
      ifb.req[0] = 1'b0;
      tick();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int c1;
      bit got;
      ifa.req = '0; ifa.op = '0; ifa.idx = '0; ifa.clear_all = 1'b0;
      ifb.req = '0; ifb.op = '0; ifb.idx = '0; ifb.clear_all = 1'b0;

      // Reset with every requester asking.
      rst = 1'b1;
      for (int r = 0; r < NREQ; r++) set_req(r, OP_SET, 3'(r + 4));
      tick();
      tick();
      chk("rst_q", 32'(ifa.q), 32'd0);
      chk("rst_ack", 32'(ifa.ack), 32'd0);
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      rst = 1'b0;
      got = 0;
      for (int n = 0; n < 8 && !got; n++) begin
         tick();
         if (ifa.ack != '0) got = 1;
      end
      chk("first_grant", 32'(ifa.ack), 32'b0001);
      ifa.req = '0;
      tick();
      ifa.clear_all = 1'b1;
      tick();
      ifa.clear_all = 1'b0;
      chk("clear_idle", 32'(ifa.q), 32'd0);

      // Single op: req1 sets cell 3.
      set_req(1, OP_SET, 3'd3);
      tick();
      chk("single_busy1", 32'(ifa.busy), 32'd1);
      chk("single_noack", 32'(ifa.ack), 32'd0);
      tick();
      chk("single_busy2", 32'(ifa.busy), 32'd1);
      chk("single_ack", 32'(ifa.ack), 32'b0010);
      chk("single_q", 32'(ifa.q), 32'h08);
      ifa.req[1] = 1'b0;
      tick();
      chk("single_idle", 32'(ifa.busy), 32'd0);

      // Toggle pair: lone requester served every 3 cycles.
      set_req(0, OP_TGL, 3'd0);
      tick();
      tick();
      chk("tgl_ack1", 32'(ifa.ack), 32'b0001);
      chk("tgl_q1", 32'(ifa.q), 32'h09);
      c1 = cyc;
      tick();
      tick();
      tick();
      chk("tgl_ack2", 32'(ifa.ack), 32'b0001);
      chk("tgl_q2", 32'(ifa.q), 32'h08);
      chk("tgl_gap", 32'(cyc - c1), 32'd3);
      ifa.req[0] = 1'b0;
      tick();

      // Round-robin with all four requesters held.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int r = 0; r < NREQ; r++) set_req(r, OP_SET, 3'(r));
      exp_q.delete();
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(3); exp_q.push_back(0);
      for (int n = 0; n < 30 && exp_q.size() > 0; n++) begin
         tick();
         if (ifa.ack != '0) chk("rr_order", 32'(ifa.ack), 32'd1 << exp_q.pop_front());
      end
      chk("rr_done", 32'(exp_q.size()), 32'd0);
      ifa.req = '0;
      tick();
      chk("rr_q", 32'(ifa.q), 32'h0F);

      // clear_all during GRANT aborts the op; it is re-granted later.
      for (int i = 0; i < NB; i++) run_op(0, OP_SET, 3'(i));
      chk("fill_q", 32'(ifa.q), 32'hFF);
      set_req(2, OP_RST, 3'd5);
      tick();
      chk("abort_in_grant", 32'(ifa.busy), 32'd1);
      ifa.clear_all = 1'b1;
      tick();
      ifa.clear_all = 1'b0;
      chk("abort_q", 32'(ifa.q), 32'd0);
      chk("abort_ack", 32'(ifa.ack), 32'd0);
      chk("abort_busy", 32'(ifa.busy), 32'd0);
      tick();
      tick();
      chk("regrant_ack", 32'(ifa.ack), 32'b0100);
      chk("regrant_q", 32'(ifa.q), 32'd0);
      ifa.req[2] = 1'b0;
      tick();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (m_ackv[r]) begin
               if ($urandom_range(1, 0) == 1) ifa.req[r] = 1'b0;
            end else if (!ifa.req[r]) begin
               if ($urandom_range(3, 0) == 0)
                  set_req(r, 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)));
            end else if ($urandom_range(63, 0) == 0) begin
               ifa.req[r] = 1'b0;
            end
         end
         ifa.clear_all = ($urandom_range(19, 0) == 0);
         tick();
      end
      ifa.req = '0;
      ifa.clear_all = 1'b0;
      tick();
      tick();
      tick();

      // Six-cell bank: out-of-range indices and hold ops still ack.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_op_b(OP_SET,  3'd1, 6'h02);
      run_op_b(OP_SET,  3'd7, 6'h02);
      run_op_b(OP_TGL,  3'd6, 6'h02);
      run_op_b(OP_HOLD, 3'd2, 6'h02);
      run_op_b(OP_SET,  3'd5, 6'h22);
      run_op_b(OP_RST,  3'd1, 6'h20);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d limit reached", cyc);
      $fatal(1, "timeout");
   end

endmodule
